rsa_mont_arbiter: RTL and testbench
===================================

Name: rsa_mont_arbiter

Overview:
- Shares one RSA modular-exponentiation engine (base/msg/key/modulus in, crypto out, valid/ready on both sides) between N_REQ independent requesters.
- Round-robin grant; one job in flight at a time.
- Latches the winner's operands, drives the engine, captures the result and returns it only to the owning requester.
- Sits between the software/DMA front-ends and the single engine instance.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- ID_W, $clog2(N_REQ) (min 1), width of the owner id.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester job valid
- req_ready  out  N_REQ  per-requester job accept; at most one bit high
- req_base  in  N_REQ x KeyType  2^2n mod N, per requester
- req_msg  in  N_REQ x KeyType  message, per requester
- req_key  in  N_REQ x KeyType  exponent, per requester
- req_modulus  in  N_REQ x KeyType  modulus N, per requester
- rsp_valid  out  N_REQ  result valid, owner bit only
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_crypto  out  KeyType  result, shared by all requesters
- rsp_id  out  ID_W  owner id of the current result
- eng_i_valid  out  1  job valid to the engine
- eng_i_ready  in  1  engine job accept
- eng_base, eng_msg, eng_key, eng_modulus  out  KeyType each  latched operands
- eng_o_valid  in  1  engine result valid
- eng_o_ready  out  1  engine result accept
- eng_crypto  in  KeyType  engine result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, owner=0.
  - All operand and result registers 0.
  - Every valid/ready output 0 except req_ready, which is combinational from IDLE.
- IDLE:
  - Winner = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits stay 0.
  - Handshake is req_valid[winner] && req_ready[winner]. On it: latch the four operands, owner<=winner, state->ISSUE.
  - No valid requester: remain in IDLE.
- ISSUE:
  - eng_i_valid=1 with the latched operands.
  - Operands are held stable until eng_i_ready.
  - On eng_i_ready: state->WAIT.
- WAIT:
  - eng_o_ready=1.
  - On eng_o_valid: result<=eng_crypto, state->DELIVER.
- DELIVER:
  - rsp_valid[owner]=1, rsp_crypto=result, rsp_id=owner.
  - Holds until rsp_ready[owner]. Then state->IDLE and rr_ptr<=(owner+1) mod N_REQ (wrap: owner N_REQ-1 -> 0).
- Outside DELIVER: rsp_valid=0, rsp_crypto=0, rsp_id=0.
- Latency: request accept to eng_i_valid is 1 cycle. eng_o_valid to rsp_valid is 1 cycle. Back-to-back jobs have 1 IDLE cycle between the response handshake and the next grant.
- While not IDLE: all req_ready=0. Other requesters' valids are ignored, but they keep priority order for the next grant.
- A requester that deasserts req_valid after acceptance has no effect on the job in flight.
- rsp_ready on a non-owner bit is ignored.
- N_REQ=1: degenerates to a registered pass-through with the same state sequence.
- Reset mid-operation aborts the job and discards the result. The engine shares rst and is reset at the same time.
- Any illegal state encoding -> IDLE.

Optional Feature:
- Macro: RSA_ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 1024) and output port rsp_drop (1 bit).
  - A counter starts on entry to DELIVER.
  - If rsp_ready[owner] is not seen within TIMEOUT cycles: the result is discarded, rsp_drop pulses for 1 cycle, state->IDLE, rr_ptr advances as for a normal completion.
- When undefined: DELIVER waits indefinitely and the port and counter do not exist.

Decomposition:
- RSA_pkg already provides KeyType and MOD_WIDTH.
- Add to RSA_pkg: ArbState_t enum (IDLE, ISSUE, WAIT, DELIVER) and RsaJob_t struct {base, msg, key, modulus}.
- One sub-module: rr_arbiter (N_REQ request vector + rr_ptr -> one-hot grant + encoded id, purely combinational), reusable elsewhere.

Test Plan:
- The bench engine model computes msg^key mod modulus and returns after 20 cycles with random eng_i_ready stalls.
- Single request: req0 {msg=5, key=3, mod=13} -> rsp_valid[0] with rsp_crypto=8, rsp_id=0; req_ready[0] high exactly 1 cycle.
- Contention: req0 and req2 valid at reset exit -> req0 served first, then req2 (msg=2, key=10, mod=1000 -> 24); rr_ptr=3 afterwards.
- Wrap-around: after req3 completes, req1 and req3 both valid -> req1 granted (pointer wrapped to 0).
- Backpressure: hold rsp_ready[1]=0 for 50 cycles -> rsp_valid/rsp_crypto stable, no new grants, eng_i_valid=0 throughout.
- Reset mid-WAIT: deassert rst for 1 cycle -> all outputs 0 immediately, busy=0; the next request completes correctly.
- With RSA_ARB_TIMEOUT_EN and TIMEOUT=8: never assert rsp_ready -> rsp_drop pulses on the 8th DELIVER cycle, and the next requester is granted.

Source files
------------

// File: rtl/RSA_pkg.sv
// rtl/RSA_pkg.sv - shared RSA key type, arbiter state encoding and job bundle
package RSA_pkg;

    localparam int MOD_WIDTH = 32;

    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } ArbState_t;

    typedef struct packed {
        KeyType base;
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RsaJob_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);

    int              idx;
    logic [ID_W-1:0] idx_id;
    logic            found;

    always_comb begin
        grant  = '0;
        id     = '0;
        found  = 1'b0;
        idx    = 0;
        idx_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx    = (int'(ptr) + i) % N_REQ;
            idx_id = ID_W'(idx);
            if (!found && req[idx_id]) begin
                found         = 1'b1;
                grant[idx_id] = 1'b1;
                id            = idx_id;
            end
        end
    end

endmodule

// File: rtl/rsa_mont_arbiter.sv
// rtl/rsa_mont_arbiter.sv - round-robin sharing of one RSA modexp engine among N_REQ requesters
// Optional DELIVER timeout with rsp_drop pulse: define RSA_ARB_TIMEOUT_EN.
module rsa_mont_arbiter
    import RSA_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
`ifdef RSA_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  KeyType           req_base    [N_REQ],
    input  KeyType           req_msg     [N_REQ],
    input  KeyType           req_key     [N_REQ],
    input  KeyType           req_modulus [N_REQ],
    output logic [N_REQ-1:0] rsp_valid,
    input  logic [N_REQ-1:0] rsp_ready,
    output KeyType           rsp_crypto,
    output logic [ID_W-1:0]  rsp_id,
    output logic             eng_i_valid,
    input  logic             eng_i_ready,
    output KeyType           eng_base,
    output KeyType           eng_msg,
    output KeyType           eng_key,
    output KeyType           eng_modulus,
    input  logic             eng_o_valid,
    output logic             eng_o_ready,
    input  KeyType           eng_crypto,
`ifdef RSA_ARB_TIMEOUT_EN
    output logic             rsp_drop,
`endif
    output logic             busy
);

    ArbState_t        state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  owner;
    RsaJob_t          job;
    KeyType           result;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  next_ptr;
    logic             deliver_done;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .id   (gnt_id)
    );

    assign next_ptr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Counts completed DELIVER cycles; the TIMEOUT-th cycle without rsp_ready drops the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == DELIVER) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit      = (state == DELIVER) && !rsp_ready[owner] && (tmo_cnt == CW'(TIMEOUT - 1));
    assign rsp_drop     = tmo_hit;
    assign deliver_done = rsp_ready[owner] || tmo_hit;
`else
    assign deliver_done = rsp_ready[owner];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            job    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & grant)) begin
                        job.base    <= req_base[gnt_id];
                        job.msg     <= req_msg[gnt_id];
                        job.key     <= req_key[gnt_id];
                        job.modulus <= req_modulus[gnt_id];
                        owner       <= gnt_id;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_i_ready) state <= WAIT;
                end
                WAIT: begin
                    if (eng_o_valid) begin
                        result <= eng_crypto;
                        state  <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (deliver_done) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output below decodes registered state only, except req_ready which follows req_valid.
    assign busy        = (state != IDLE);
    assign req_ready   = (state == IDLE) ? grant : '0;
    assign eng_i_valid = (state == ISSUE);
    assign eng_o_ready = (state == WAIT);
    assign eng_base    = job.base;
    assign eng_msg     = job.msg;
    assign eng_key     = job.key;
    assign eng_modulus = job.modulus;
    assign rsp_valid   = (state == DELIVER) ? (N_REQ'(1) << owner) : '0;
    assign rsp_crypto  = (state == DELIVER) ? result : '0;
    assign rsp_id      = (state == DELIVER) ? owner : '0;

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// tb/tb_rsa_mont_arbiter.sv - directed bench for rsa_mont_arbiter with a modexp engine model
module tb_rsa_mont_arbiter;
    import RSA_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    KeyType     req_base    [4];
    KeyType     req_msg     [4];
    KeyType     req_key     [4];
    KeyType     req_modulus [4];
    logic [3:0] rsp_valid;
    logic [3:0] rsp_ready;
    KeyType     rsp_crypto;
    logic [1:0] rsp_id;
    logic       eng_i_valid;
    logic       eng_i_ready;
    KeyType     eng_base, eng_msg, eng_key, eng_modulus;
    logic       eng_o_valid;
    logic       eng_o_ready;
    KeyType     eng_crypto;
    logic       busy;
`ifdef RSA_ARB_TIMEOUT_EN
    logic       rsp_drop;
`endif

    int total = 0;
    int bad   = 0;

`ifdef RSA_ARB_TIMEOUT_EN
    rsa_mont_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
`else
    rsa_mont_arbiter #(.N_REQ(4)) dut (
`endif
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_msg(req_msg), .req_key(req_key), .req_modulus(req_modulus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_crypto(rsp_crypto), .rsp_id(rsp_id),
        .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
        .eng_base(eng_base), .eng_msg(eng_msg), .eng_key(eng_key), .eng_modulus(eng_modulus),
        .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_crypto(eng_crypto),
`ifdef RSA_ARB_TIMEOUT_EN
        .rsp_drop(rsp_drop),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic KeyType modexp(input KeyType b, input KeyType e, input KeyType m);
        longint unsigned r, x;
        r = 64'd1 % m;
        x = b % m;
        for (int i = 0; i < MOD_WIDTH; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return KeyType'(r);
    endfunction

    // Engine model: random input stalls, result presented 20 cycles after accept.
    logic   e_busy;
    int     e_cnt;
    KeyType e_res;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_busy      <= 1'b0;
            e_cnt       <= 0;
            e_res       <= '0;
            eng_i_ready <= 1'b0;
            eng_o_valid <= 1'b0;
            eng_crypto  <= '0;
        end else if (!e_busy) begin
            if (eng_i_valid && eng_i_ready) begin
                e_busy      <= 1'b1;
                e_cnt       <= 0;
                eng_i_ready <= 1'b0;
                e_res       <= modexp(eng_msg, eng_key, eng_modulus);
            end else begin
                eng_i_ready <= ($urandom_range(0, 3) != 0);
            end
        end else if (eng_o_valid && eng_o_ready) begin
            eng_o_valid <= 1'b0;
            e_busy      <= 1'b0;
        end else if (e_cnt == 19) begin
            eng_o_valid <= 1'b1;
            eng_crypto  <= e_res;
        end else begin
            e_cnt <= e_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int i, input KeyType m, input KeyType k, input KeyType n);
        req_base[i]    = 32'h1234_0000 + KeyType'(i);
        req_msg[i]     = m;
        req_key[i]     = k;
        req_modulus[i] = n;
    endtask

    task automatic wait_rsp(input int idx);
        int n;
        n = 0;
        while (!rsp_valid[idx] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("rsp_arrives_%0d", idx), {63'd0, rsp_valid[idx]}, 64'd1);
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 4; i++) set_job(i, 0, 0, 1);

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_eng_i_valid", eng_i_valid, 0);
        chk("rst_eng_o_ready", eng_o_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_crypto", rsp_crypto, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_eng_msg", eng_msg, 0);
        set_job(0, 5, 3, 13);
        req_valid = 4'b0001;
        #1 chk("rst_req_ready_comb", req_ready, 4'b0001);

        // Single request
        @(negedge clk);
        rst = 1'b1;
        #1 chk("single_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("single_busy", busy, 1);
        chk("single_ready_once", req_ready, 0);
        chk("single_issue", eng_i_valid, 1);
        chk("single_ops", {eng_msg, eng_key}, {32'd5, 32'd3});
        chk("single_mod", eng_modulus, 13);
        chk("single_base", eng_base, 32'h1234_0000);
        wait_rsp(0);
        chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_crypto", rsp_crypto, 8);
        chk("single_id", rsp_id, 0);
        @(negedge clk);
        chk("single_idle", busy, 0);
        chk("single_rsp_clear", rsp_valid, 0);

        // Contention from reset: req0 before req2
        rst = 1'b0;
        set_job(2, 2, 10, 1000);
        req_valid = 4'b0101;
        @(negedge clk);
        rst = 1'b1;
        #1 chk("cont_grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0100;
        #1 chk("cont_busy_no_ready", req_ready, 0);
        wait_rsp(0);
        chk("cont_crypto0", rsp_crypto, 8);
        @(negedge clk);
        #1 chk("cont_grant2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(2);
        chk("cont_crypto2", rsp_crypto, 24);
        chk("cont_id2", rsp_id, 2);
        @(negedge clk);
        set_job(3, 3, 4, 7);
        set_job(1, 7, 2, 10);
        req_valid = 4'b1111;
        #1 chk("ptr_is_3", req_ready, 4'b1000);

        // Wrap-around, then backpressure on req1
        @(negedge clk);
        req_valid = 4'b1010;
        rsp_ready = 4'b1101;
        wait_rsp(3);
        chk("wrap_crypto3", rsp_crypto, 4);
        chk("wrap_id3", rsp_id, 3);
        @(negedge clk);
        #1 chk("wrap_grant1", req_ready, 4'b0010);
        wait_rsp(1);
        for (int k = 0; k < 50; k++) begin
            chk($sformatf("bp_cycle_%0d", k), {rsp_valid, rsp_crypto, req_ready, eng_i_valid, rsp_id},
                {4'b0010, 32'd9, 4'b0000, 1'b0, 2'd1});
            @(negedge clk);
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        #1 chk("bp_then_grant3", req_ready, 4'b1000);

        // Reset while the engine job is in WAIT
        @(negedge clk);
        req_valid = 4'b0000;
        n = 0;
        while (!eng_o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait", eng_o_ready, 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_outs", {eng_o_ready, eng_i_valid, rsp_valid, req_ready}, 0);
        chk("midrst_ops", eng_msg, 0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0100;
        #1 chk("midrst_grant2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(2);
        chk("midrst_crypto2", rsp_crypto, 24);
        chk("midrst_id2", rsp_id, 2);

`ifdef RSA_ARB_TIMEOUT_EN
        @(negedge clk);
        rsp_ready = 4'b0000;
        req_valid = 4'b0011;
        #1 chk("tmo_grant0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        wait_rsp(0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("tmo_drop_%0d", k), rsp_drop, (k == 8) ? 1 : 0);
            @(negedge clk);
        end
        #1;
        chk("tmo_rsp_gone", rsp_valid, 0);
        chk("tmo_next_grant", req_ready, 4'b0010);
        req_valid = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
